// File: rtl/mlp_load_sequencer.sv
// mlp_load_sequencer: buffers a flat host word stream and replays it as gap-free
// row bursts in the MLP accelerator load protocol (layer 0 carries inputs + weights).
module mlp_load_sequencer #(
    parameter int unsigned FIFO_DEPTH    = 32,
    parameter int unsigned ROWS          = 16,
    parameter int unsigned BEATS_PER_ROW = 8,
    parameter int unsigned LAYERS        = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic                          in_valid_i,
    input  logic [31:0]                   in_data_i,
    output logic                          in_ready_o,
    output logic                          load_en_o,
    output logic [31:0]                   load_payload_o,
    output logic                          load_type_o,
    output logic [$clog2(ROWS)-1:0]       input_load_number_o,
    output logic [$clog2(LAYERS)-1:0]     layer_number_o,
    output logic [$clog2(BEATS_PER_ROW)-1:0] weight_number_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W       = PTR_W + 1;
    localparam int unsigned ROW_W       = $clog2(ROWS);
    localparam int unsigned LAYER_W     = $clog2(LAYERS);
    localparam int unsigned WN_W        = $clog2(BEATS_PER_ROW);
    localparam int unsigned BEAT_W      = $clog2(2 * BEATS_PER_ROW);
    localparam int unsigned TOTAL_WORDS = ROWS * 2 * BEATS_PER_ROW
                                        + (LAYERS - 1) * ROWS * BEATS_PER_ROW;
    localparam int unsigned ACC_W       = $clog2(TOTAL_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ROW = 2'd1,
        BURST    = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                 state;
    logic [DATA_W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       fifo_count;
    logic [ACC_W-1:0]       accepted_cnt;
    logic [ROW_W-1:0]       row_cnt;
    logic [LAYER_W-1:0]     layer_cnt;
    logic [BEAT_W-1:0]      beat_cnt;

    logic                   fifo_full_c;
    logic                   push_c;
    logic                   pop_c;
    logic                   job_start_c;
    logic                   is_input_c;
    logic [CNT_W-1:0]       need_c;
    logic [BEAT_W-1:0]      last_beat_c;

    // Handshake, pop and per-row geometry derived from registered state only
    assign fifo_full_c = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign in_ready_o  = busy_o & ~fifo_full_c & (accepted_cnt < ACC_W'(TOTAL_WORDS));
    assign push_c      = in_valid_i & in_ready_o;
    assign pop_c       = (state == BURST);
    assign job_start_c = (state == IDLE) & start_i;
    assign need_c      = (layer_cnt == '0) ? CNT_W'(2 * BEATS_PER_ROW) : CNT_W'(BEATS_PER_ROW);
    assign last_beat_c = (layer_cnt == '0) ? BEAT_W'(2 * BEATS_PER_ROW - 1)
                                           : BEAT_W'(BEATS_PER_ROW - 1);
    assign is_input_c  = (layer_cnt == '0) && (beat_cnt < BEAT_W'(BEATS_PER_ROW));

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= in_data_i;
        end
    end

    // FIFO pointers, occupancy and per-job accepted word count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            accepted_cnt <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (job_start_c) begin
                accepted_cnt <= '0;
            end else if (push_c) begin
                accepted_cnt <= accepted_cnt + ACC_W'(1);
            end
        end
    end

    // Row sequencer: waits for a full row in the FIFO, then issues it as one burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            row_cnt             <= '0;
            layer_cnt           <= '0;
            beat_cnt            <= '0;
            load_en_o           <= 1'b0;
            load_payload_o      <= '0;
            load_type_o         <= 1'b0;
            input_load_number_o <= '0;
            layer_number_o      <= '0;
            weight_number_o     <= '0;
            busy_o              <= 1'b0;
            done_o              <= 1'b0;
        end else begin
            load_en_o <= 1'b0;
            done_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state     <= WAIT_ROW;
                        busy_o    <= 1'b1;
                        row_cnt   <= '0;
                        layer_cnt <= '0;
                        beat_cnt  <= '0;
                    end
                end
                WAIT_ROW: begin
                    if (fifo_count >= need_c) begin
                        state <= BURST;
                    end
                end
                BURST: begin
                    load_en_o           <= 1'b1;
                    load_payload_o      <= mem[rd_ptr];
                    load_type_o         <= is_input_c;
                    weight_number_o     <= is_input_c ? '0 : beat_cnt[WN_W-1:0];
                    input_load_number_o <= row_cnt;
                    layer_number_o      <= layer_cnt;
                    if (beat_cnt == last_beat_c) begin
                        beat_cnt <= '0;
                        if (row_cnt == ROW_W'(ROWS - 1)) begin
                            row_cnt <= '0;
                            if (layer_cnt == LAYER_W'(LAYERS - 1)) begin
                                state  <= DONE;
                                done_o <= 1'b1;
                                busy_o <= 1'b0;
                            end else begin
                                layer_cnt <= layer_cnt + LAYER_W'(1);
                                state     <= WAIT_ROW;
                            end
                        end else begin
                            row_cnt <= row_cnt + ROW_W'(1);
                            state   <= WAIT_ROW;
                        end
                    end else begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_load_sequencer.sv
// Directed bench for mlp_load_sequencer: full jobs, throttled host, pre-start pushes,
// mid-job reset and restart/overflow attempts.
module tb_mlp_load_sequencer;

    localparam int TOTAL  = 1152;
    localparam int BUDGET = 8000;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        in_valid_i;
    logic [31:0] in_data_i;
    logic        in_ready_o;
    logic        load_en_o;
    logic [31:0] load_payload_o;
    logic        load_type_o;
    logic [3:0]  input_load_number_o;
    logic [2:0]  layer_number_o;
    logic [2:0]  weight_number_o;
    logic        busy_o;
    logic        done_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] p;
        logic        t;
        logic [3:0]  r;
        logic [2:0]  l;
        logic [2:0]  w;
        int          c;
    } beat_t;

    beat_t q[$];
    beat_t mb;
    int    acc_cnt   = 0;
    int    done_seen = 0;
    int    full_viol = 0;

    mlp_load_sequencer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start_i             (start_i),
        .in_valid_i          (in_valid_i),
        .in_data_i           (in_data_i),
        .in_ready_o          (in_ready_o),
        .load_en_o           (load_en_o),
        .load_payload_o      (load_payload_o),
        .load_type_o         (load_type_o),
        .input_load_number_o (input_load_number_o),
        .layer_number_o      (layer_number_o),
        .weight_number_o     (weight_number_o),
        .busy_o              (busy_o),
        .done_o              (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Beat recorder, done counter and FIFO-full handshake monitor
    always @(negedge clk) begin
        if (load_en_o === 1'b1) begin
            mb.p = load_payload_o;
            mb.t = load_type_o;
            mb.r = input_load_number_o;
            mb.l = layer_number_o;
            mb.w = weight_number_o;
            mb.c = cyc;
            q.push_back(mb);
        end
        if (done_o === 1'b1) done_seen++;
        if (in_ready_o === 1'b1 && (acc_cnt - q.size()) >= 32) full_viol++;
    end

    // Expected protocol fields for the k-th word of a job
    function automatic void exp_beat(input int k, output logic t, output logic [3:0] r,
                                     output logic [2:0] l, output logic [2:0] w);
        int v;
        if (k < 256) begin
            l = 3'd0;
            r = 4'(k / 16);
            t = ((k % 16) < 8);
            w = t ? 3'd0 : 3'((k % 16) - 8);
        end else begin
            v = k - 256;
            l = 3'(1 + v / 128);
            r = 4'((v % 128) / 8);
            t = 1'b0;
            w = 3'(v % 8);
        end
    endfunction

    function automatic int seq_errs(input logic [31:0] base);
        int e;
        logic t;
        logic [3:0] r;
        logic [2:0] l, w;
        e = 0;
        for (int k = 0; k < q.size() && k < TOTAL; k++) begin
            exp_beat(k, t, r, l, w);
            if (q[k].p !== base + 32'(k) || q[k].t !== t || q[k].r !== r ||
                q[k].l !== l || q[k].w !== w) e++;
        end
        return e;
    endfunction

    // Counts gaps inside a row burst and rows issued back-to-back without an idle cycle
    function automatic int gap_errs();
        int e;
        e = 0;
        for (int i = 1; i < q.size(); i++) begin
            if (q[i].l == q[i-1].l && q[i].r == q[i-1].r) begin
                if (q[i].c != q[i-1].c + 1) e++;
            end else if (q[i].c < q[i-1].c + 2) begin
                e++;
            end
        end
        return e;
    endfunction

    task automatic clear_mon();
        q.delete();
        acc_cnt   = 0;
        done_seen = 0;
        full_viol = 0;
    endtask

    // Host model: starts a job, offers words every `period` cycles, optional extra start/abort
    task automatic feed(input logic [31:0] base, input int period, input bit offer_extra,
                        input int restart_at, input bit start_on_done, input bit abort_l3,
                        output bit finished, output bit aborted, output int sent);
        int n;
        bit fire;
        n = 0;
        sent = 0;
        finished = 1'b0;
        aborted = 1'b0;
        while (!finished && !aborted && n < BUDGET) begin
            @(negedge clk);
            if (abort_l3 && load_en_o === 1'b1 && layer_number_o == 3'd3 &&
                input_load_number_o == 4'd7 && weight_number_o == 3'd4) begin
                rst_n      = 1'b0;
                in_valid_i = 1'b0;
                start_i    = 1'b0;
                aborted    = 1'b1;
            end else begin
                if (done_o === 1'b1) begin
                    finished = 1'b1;
                    start_i  = start_on_done;
                end else begin
                    start_i = (n == 0) || (n == restart_at);
                end
                in_valid_i = ((n % period) == 0) && (offer_extra || sent < TOTAL);
                in_data_i  = base + 32'(sent);
                #1;
                fire = in_valid_i && (in_ready_o === 1'b1);
                @(posedge clk);
                if (fire) begin
                    sent++;
                    acc_cnt++;
                end
                n++;
            end
        end
        if (!aborted) begin
            @(negedge clk);
            start_i    = 1'b0;
            in_valid_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({load_en_o, load_payload_o, load_type_o, input_load_number_o, layer_number_o,
             weight_number_o, busy_o, done_o, in_ready_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: load_en=%b payload=%h busy=%b done=%b ready=%b, required all 0",
                     load_en_o, load_payload_o, busy_o, done_o, in_ready_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || load_en_o !== 1'b0 || in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b load_en=%b ready=%b, required 0 0 0",
                     busy_o, load_en_o, in_ready_o);
        end
    endtask

    task automatic test_full_job();
        bit fin, ab;
        int sent, e;
        clear_mon();
        feed(32'h0, 1, 1'b0, -1, 1'b0, 1'b0, fin, ab, sent);
        checks++;
        if (!fin) begin errors++; $display("FAIL full_done_timeout: done seen=%0b, required 1", fin); end
        checks++;
        if (q.size() !== TOTAL) begin errors++; $display("FAIL full_beat_count: got %0d, required %0d", q.size(), TOTAL); end
        e = seq_errs(32'h0);
        checks++;
        if (e !== 0) begin errors++; $display("FAIL full_sequence: %0d bad beats, required 0", e); end
        checks++;
        if (q.size() < 257) begin
            errors++; $display("FAIL full_spot: only %0d beats, required >= 257", q.size());
        end else begin
            if (q[0].p !== 32'd0 || q[0].t !== 1'b1 || q[0].l !== 3'd0) begin
                errors++; $display("FAIL l0r0b0: payload=%h type=%b, required 0 1", q[0].p, q[0].t);
            end
            checks++;
            if (q[8].p !== 32'd8 || q[8].t !== 1'b0 || q[8].w !== 3'd0) begin
                errors++; $display("FAIL l0r0b8: payload=%h type=%b wn=%0d, required 8 0 0", q[8].p, q[8].t, q[8].w);
            end
            checks++;
            if (q[256].p !== 32'd256 || q[256].l !== 3'd1 || q[256].r !== 4'd0) begin
                errors++; $display("FAIL l1r0b0: payload=%h layer=%0d, required 256 1", q[256].p, q[256].l);
            end
        end
        e = gap_errs();
        checks++;
        if (e !== 0) begin errors++; $display("FAIL full_gaps: %0d burst gaps, required 0", e); end
        repeat (3) @(negedge clk);
        checks++;
        if (done_seen !== 1) begin errors++; $display("FAIL full_done_once: %0d pulses, required 1", done_seen); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL full_busy_end: busy=%b, required 0", busy_o); end
    endtask

    task automatic test_throttled();
        bit fin, ab;
        int sent, e;
        clear_mon();
        feed(32'hA000_0000, 3, 1'b0, -1, 1'b0, 1'b0, fin, ab, sent);
        checks++;
        if (!fin || q.size() !== TOTAL) begin
            errors++; $display("FAIL thr_count: done=%0b beats=%0d, required 1 %0d", fin, q.size(), TOTAL);
        end
        e = seq_errs(32'hA000_0000);
        checks++;
        if (e !== 0) begin errors++; $display("FAIL thr_sequence: %0d bad beats, required 0", e); end
        e = gap_errs();
        checks++;
        if (e !== 0) begin errors++; $display("FAIL thr_gaps: %0d burst gaps, required 0", e); end
        checks++;
        if (full_viol !== 0) begin errors++; $display("FAIL thr_ready_full: %0d cycles, required 0", full_viol); end
    endtask

    task automatic test_prestart();
        bit fin, ab;
        int sent, e;
        clear_mon();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid_i = 1'b1;
            in_data_i  = 32'hDEAD_0000 + 32'(i);
            #1;
            checks++;
            if (in_ready_o !== 1'b0) begin
                errors++; $display("FAIL prestart_ready[%0d]: ready=%b, required 0", i, in_ready_o);
            end
        end
        @(negedge clk);
        in_valid_i = 1'b0;
        feed(32'h0000_5000, 1, 1'b0, -1, 1'b0, 1'b0, fin, ab, sent);
        checks++;
        if (q.size() == 0 || q[0].p !== 32'h0000_5000 || q[0].t !== 1'b1) begin
            errors++;
            $display("FAIL prestart_first_beat: beats=%0d payload=%h, required payload 00005000",
                     q.size(), (q.size() > 0) ? q[0].p : 32'hx);
        end
        e = seq_errs(32'h0000_5000);
        checks++;
        if (!fin || q.size() !== TOTAL || e !== 0) begin
            errors++; $display("FAIL prestart_sequence: beats=%0d bad=%0d, required %0d 0", q.size(), e, TOTAL);
        end
    endtask

    task automatic test_reset_midjob();
        bit fin, ab;
        int sent, e;
        clear_mon();
        feed(32'h0, 1, 1'b0, -1, 1'b0, 1'b1, fin, ab, sent);
        checks++;
        if (!ab) begin errors++; $display("FAIL abort_point: L3 r7 b4 seen=%0b, required 1", ab); end
        #1;
        checks++;
        if ({load_en_o, load_payload_o, load_type_o, input_load_number_o, layer_number_o,
             weight_number_o, busy_o, done_o, in_ready_o} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: load_en=%b payload=%h layer=%0d busy=%b, required all 0",
                     load_en_o, load_payload_o, layer_number_o, busy_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        feed(32'h0, 1, 1'b0, -1, 1'b0, 1'b0, fin, ab, sent);
        checks++;
        if (q.size() == 0 || q[0].p !== 32'd0 || q[0].l !== 3'd0 || q[0].r !== 4'd0 || q[0].t !== 1'b1) begin
            errors++; $display("FAIL abort_restart_first: beats=%0d, required word 0 as L0 r0 input beat", q.size());
        end
        e = seq_errs(32'h0);
        checks++;
        if (!fin || q.size() !== TOTAL || e !== 0) begin
            errors++; $display("FAIL abort_restart_seq: beats=%0d bad=%0d, required %0d 0", q.size(), e, TOTAL);
        end
    endtask

    task automatic test_back_to_back();
        bit fin, ab;
        int sent, e;
        clear_mon();
        feed(32'h0055_0000, 1, 1'b1, 400, 1'b1, 1'b0, fin, ab, sent);
        checks++;
        if (sent !== TOTAL) begin errors++; $display("FAIL extra_word: accepted %0d, required %0d", sent, TOTAL); end
        e = seq_errs(32'h0055_0000);
        checks++;
        if (!fin || q.size() !== TOTAL || e !== 0) begin
            errors++; $display("FAIL restart_ignored: beats=%0d bad=%0d, required %0d 0", q.size(), e, TOTAL);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (done_seen !== 1) begin errors++; $display("FAIL b2b_done_once: %0d pulses, required 1", done_seen); end
        checks++;
        if (busy_o !== 1'b0 || load_en_o !== 1'b0) begin
            errors++; $display("FAIL start_on_done_ignored: busy=%b load_en=%b, required 0 0", busy_o, load_en_o);
        end
    endtask

    initial begin
        test_reset();
        test_full_job();
        test_throttled();
        test_prestart();
        test_reset_midjob();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
